// File: rtl/shift_sequencer_64_if.sv
// Request/result bundle for the multi-cycle shift sequencer.
// The sequencer uses the slave modport; the issuing stage uses master.
interface shift_sequencer_64_if #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
);
    logic               start_i;
    logic               ready_o;
    logic [1:0]         op_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic [WIDTH-1:0]   data_i;
    logic               flush_i;
    logic [WIDTH-1:0]   result_o;
    logic               valid_o;
    logic               ack_i;
    logic               busy_o;

    modport slave (
        input  start_i, op_i, shamt_i, data_i, flush_i, ack_i,
        output ready_o, result_o, valid_o, busy_o
    );

    modport master (
        output start_i, op_i, shamt_i, data_i, flush_i, ack_i,
        input  ready_o, result_o, valid_o, busy_o
    );
endinterface

// File: rtl/shift_sequencer_64.sv
// Multi-cycle shifter: one single-bit shift step per clock until the requested
// amount is reached, with the result presented through a valid/ack handshake.
module shift_sequencer_64 #(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    shift_sequencer_64_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    state_t             state_q;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   data_d;
    logic [WIDTH-1:0]   result_q;
    logic               ready_q;
    logic               valid_q;
    logic               busy_q;

    function automatic logic [WIDTH-1:0] shift_step(input logic [1:0] op,
                                                    input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
            default: r = {d[WIDTH-2:0], d[WIDTH-1]};
        endcase
        return r;
    endfunction

    always_comb begin
        data_d = shift_step(op_q, data_q);
    end

    // Flags and result are registered so the handshake outputs are glitch-free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            op_q     <= OP_SLL;
            cnt_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!bus.flush_i && bus.start_i) begin
                        data_q  <= bus.data_i;
                        op_q    <= bus.op_i;
                        cnt_q   <= bus.shamt_i;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        if (bus.shamt_i == '0) begin
                            state_q  <= S_DONE;
                            result_q <= bus.data_i;
                            valid_q  <= 1'b1;
                        end else begin
                            state_q <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    if (bus.flush_i) begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        data_q <= data_d;
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == SHAMT_W'(1)) begin
                            state_q  <= S_DONE;
                            result_q <= data_d;
                            valid_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.flush_i || bus.ack_i) begin
                        state_q  <= S_IDLE;
                        result_q <= '0;
                        ready_q  <= 1'b1;
                        valid_q  <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    result_q <= '0;
                    ready_q  <= 1'b1;
                    valid_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.valid_o  = valid_q;
    assign bus.busy_o   = busy_q;
    assign bus.result_o = result_q;
endmodule

// File: tb/tb_shift_sequencer_64.sv
// Bench for shift_sequencer_64: directed cases followed by randomized operations
// compared against an arithmetic reference of the four shift kinds.
module tb_shift_sequencer_64;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    shift_sequencer_64_if #(.WIDTH(64), .SHAMT_W(6)) bus ();

    shift_sequencer_64 #(.WIDTH(64), .SHAMT_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_shift(input logic [1:0] op, input logic [5:0] sh,
                                              input logic [63:0] d);
        logic signed [63:0] sd;
        logic [6:0]         amt;
        logic [63:0]        r;
        sd  = d;
        amt = {1'b0, sh};
        case (op)
            2'b00:   r = d << amt;
            2'b01:   r = d >> amt;
            2'b10:   r = sd >>> amt;
            default: r = (amt == 7'd0) ? d : ((d << amt) | (d >> (7'd64 - amt)));
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; flush_at>0 aborts during SHIFT, noise pulses start_i while busy.
    task automatic run_op(input logic [1:0] op, input logic [5:0] sh, input logic [63:0] d,
                          input logic [63:0] exp, input int ack_wait, input int flush_at,
                          input bit noise, input string tag);
        int          lat;
        int          w;
        bit          flushed;
        logic [63:0] held;
        w = 0;
        while (!bus.ready_o && w < 10) begin
            step();
            w++;
        end
        check({tag, ".ready"}, 64'(bus.ready_o), 64'd1);
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.shamt_i = sh;
        bus.data_i  = d;
        step();
        bus.start_i = 1'b0;
        lat     = 1;
        flushed = 1'b0;
        while (!bus.valid_o && lat < 80) begin
            if (flush_at > 0 && lat == flush_at) begin
                bus.flush_i = 1'b1;
                step();
                bus.flush_i = 1'b0;
                flushed     = 1'b1;
                break;
            end
            bus.start_i = noise & lat[0];
            bus.data_i  = {$urandom, $urandom};
            bus.shamt_i = 6'($urandom_range(0, 63));
            step();
            lat++;
        end
        bus.start_i = 1'b0;
        if (flushed) begin
            check({tag, ".flush_ready"}, 64'(bus.ready_o), 64'd1);
            check({tag, ".flush_busy"}, 64'(bus.busy_o), 64'd0);
            for (int i = 0; i < int'(sh) + 2; i++) begin
                check({tag, ".flush_novalid"}, 64'(bus.valid_o), 64'd0);
                step();
            end
            return;
        end
        check({tag, ".latency"}, 64'(lat), 64'(int'(sh) + 1));
        check({tag, ".result"}, bus.result_o, exp);
        check({tag, ".busy"}, 64'(bus.busy_o), 64'd1);
        check({tag, ".inv"}, 64'(bus.valid_o & bus.ready_o), 64'd0);
        held = bus.result_o;
        for (int i = 0; i < ack_wait; i++) begin
            bus.start_i = noise & i[0];
            bus.ack_i   = 1'b0;
            step();
        end
        bus.start_i = 1'b0;
        if (ack_wait > 0) begin
            check({tag, ".hold_valid"}, 64'(bus.valid_o), 64'd1);
            check({tag, ".hold_result"}, bus.result_o, held);
        end
        bus.ack_i = 1'b1;
        step();
        bus.ack_i = 1'b0;
        check({tag, ".ack_valid"}, 64'(bus.valid_o), 64'd0);
        check({tag, ".ack_ready"}, 64'(bus.ready_o), 64'd1);
        check({tag, ".ack_result"}, bus.result_o, 64'd0);
        if (noise) begin
            step();
            check({tag, ".no_second"}, 64'(bus.valid_o | bus.busy_o), 64'd0);
        end
    endtask

    initial begin
        logic [1:0]  rop;
        logic [5:0]  rsh;
        logic [63:0] rd;
        int          fat;
        tests       = 0;
        fails       = 0;
        rst         = 1'b1;
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.shamt_i = '0;
        bus.data_i  = '0;
        bus.flush_i = 1'b0;
        bus.ack_i   = 1'b0;
        step();
        step();
        rst = 1'b0;
        check("rst.ready", 64'(bus.ready_o), 64'd1);
        check("rst.valid", 64'(bus.valid_o), 64'd0);
        check("rst.busy", 64'(bus.busy_o), 64'd0);
        check("rst.result", bus.result_o, 64'd0);

        run_op(2'b00, 6'd4, 64'h1, 64'h10, 0, 0, 1'b0, "sll4");
        run_op(2'b01, 6'd0, 64'hDEAD_BEEF_0000_1234, 64'hDEAD_BEEF_0000_1234, 1, 0, 1'b0, "srl0");
        run_op(2'b00, 6'd63, 64'h1, 64'h8000_0000_0000_0000, 0, 0, 1'b0, "sll63");
        run_op(2'b10, 6'd4, 64'hF000_0000_0000_0000, 64'hFF00_0000_0000_0000, 0, 0, 1'b0, "sra4");
        run_op(2'b01, 6'd4, 64'hF000_0000_0000_0000, 64'h0F00_0000_0000_0000, 0, 0, 1'b0, "srl4");
        run_op(2'b11, 6'd1, 64'h8000_0000_0000_0001, 64'h3, 0, 0, 1'b0, "rol1");
        run_op(2'b00, 6'd2, 64'h5, 64'h14, 10, 0, 1'b0, "hold10");
        run_op(2'b00, 6'd8, 64'h1, 64'h100, 6, 0, 1'b1, "noise");
        run_op(2'b01, 6'd20, 64'hFFFF_0000_FFFF_0000, 64'h0, 0, 2, 1'b0, "flush");

        // Flush wins over start while idle.
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.shamt_i = 6'd3;
        step();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        check("idleflush.ready", 64'(bus.ready_o), 64'd1);
        check("idleflush.busy", 64'(bus.busy_o), 64'd0);

        // Reset in the middle of a long shift.
        bus.start_i = 1'b1;
        bus.op_i    = 2'b00;
        bus.shamt_i = 6'd30;
        bus.data_i  = 64'h7;
        step();
        bus.start_i = 1'b0;
        step();
        step();
        check("midrst.busy_before", 64'(bus.busy_o), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst.ready", 64'(bus.ready_o), 64'd1);
        check("midrst.valid", 64'(bus.valid_o), 64'd0);
        check("midrst.busy", 64'(bus.busy_o), 64'd0);
        check("midrst.result", bus.result_o, 64'd0);
        run_op(2'b00, 6'd1, 64'h3, 64'h6, 0, 0, 1'b0, "after_rst");

        for (int n = 0; n < 1000; n++) begin
            rop = 2'($urandom_range(0, 3));
            rsh = 6'($urandom_range(0, 63));
            rd  = {$urandom, $urandom};
            fat = 0;
            if (rsh != 6'd0 && $urandom_range(0, 9) == 0)
                fat = $urandom_range(1, int'(rsh));
            run_op(rop, rsh, rd, ref_shift(rop, rsh, rd), $urandom_range(0, 4), fat,
                   1'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
